seg7_scan_display: RTL
======================

Name: seg7_scan_display

Overview:
Time-multiplexed driver for the board's 8-digit common-anode 7-segment display. It takes a 32-bit value through a valid/ready load port and shows it as 8 hex digits. It sits directly upstream of the seg/ans pins in top, between the datapath result and the display. New values are committed only at frame boundaries, so the display never shows a torn value.

Parameters:
CLK_DIV, 100000, system clocks per digit slot (100 MHz clock gives 1 kHz digit rate, 125 Hz frame rate); legal range >= 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
load_valid  in  1  load_data is valid this cycle
load_ready  out  1  block can accept a load (pending slot empty)
load_data  in  32  value to display; digit i = load_data[4i+3:4i], digit 0 is rightmost
frame_done  out  1  one-cycle pulse when a frame completes and the shadow value is (re)committed
seg  out  7  segments {g,f,e,d,c,b,a}, active low
ans  out  8  digit enables, active low, ans[i] selects digit i

Behaviour:
- One clock domain; all state updates on rising clk; rst is synchronous and active-high.
- Reset values: div_cnt=0, digit_idx=0, shadow=0, pending_full=0, ans=8'hFF, seg=7'h7F, frame_done=0, load_ready=1.
- Prescaler: div_cnt counts 0..CLK_DIV-1 and wraps to 0. tick=1 when div_cnt==CLK_DIV-1.
- digit_idx (3 bits) increments on tick and wraps 7->0. A frame boundary is tick && digit_idx==7.
- Load handshake: a transfer occurs when load_valid && load_ready. On transfer, pending <= load_data and pending_full <= 1 on the next cycle. load_ready = ~pending_full. The upstream stage holds load_valid and load_data until ready.
- At a frame boundary:
  - If pending_full: shadow <= pending, pending_full <= 0.
  - frame_done = 1 for that one cycle, registered, so it is visible the cycle after the boundary edge.
- Simultaneous load and boundary: the new value goes to pending, not shadow. It is committed at the following boundary. The old pending value (if any) is committed at this boundary. Because ready was high, pending was empty, so nothing is lost.
- Output stage (registered, 1-cycle latency from digit_idx/shadow):
  - ans <= ~(8'b1 << digit_idx)
  - seg <= hex7(shadow[4*digit_idx +: 4])
- hex7 patterns (active low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Exactly one ans bit is low at any time outside reset, unless blanked (see Optional Feature).
- Reset mid-operation: pending is discarded, shadow clears to 0, and scanning restarts at digit 0 with a full prescaler period.

Optional Feature:
Macro: LEADING_ZERO_BLANK_EN
- Defined: a digit i>0 is blanked if all nibbles i..7 of shadow are zero. A blanked digit drives ans all-high (8'hFF) and seg=7'h7F for its slot. Scan timing is unchanged. Digit 0 is never blanked, so a value of 0 shows a single "0".
- Undefined: all 8 digits are always driven, including leading zeros.

Test Plan:
1. CLK_DIV=4; hold rst 2 cycles -> ans=FF, seg=7F during rst. Cycle after release: ans=FE, seg=40. ans advances to FD after 4 cycles.
2. Load 0x12345678 right after reset -> load_ready=0 the next cycle. At the boundary (cycle 32) frame_done pulses and load_ready returns to 1. Next frame: ans=FE shows seg=00 ('8'); ans=7F shows seg=79 ('1').
3. Back-to-back: load 0xAAAAAAAA, then hold load_valid with 0x55555555 -> second value stalls (ready=0) until the boundary. It is accepted the cycle after and displayed one frame later.
4. Assert load_valid with 0xFFFFFFFF on the exact boundary cycle -> that frame_done commits the previous value. 0xFFFFFFFF (seg=0E on all digits) appears only after the next boundary.
5. Shadow = 0x000000A5: with LEADING_ZERO_BLANK_EN, ans=FF during slots 2..7 and slots 0/1 show 12/08. Without the macro, slot 7 shows ans=7F, seg=40.
6. Load 0xDEADBEEF, pulse rst mid-frame before the boundary -> pending is dropped, ans=FF during rst, and all digits then show 40 ('0').

Source files
------------

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 8-digit hex driver for a common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seg7_scan_display #(
    parameter int unsigned CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    output logic        frame_done,
    output logic [6:0]  seg,
    output logic [7:0]  ans
);

    localparam int unsigned CntW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]      digit_idx_q, digit_idx_d;
    logic [31:0]     shadow_q, shadow_d;
    logic [31:0]     pending_q, pending_d;
    logic            pending_full_q, pending_full_d;
    logic            frame_done_q, frame_done_d;
    logic [6:0]      seg_q, seg_d;
    logic [7:0]      ans_q, ans_d;

    logic       tick;
    logic       frame_bnd;
    logic       xfer;
    logic [3:0] nibble;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] p;
        unique case (v)
            4'h0: p = 7'h40;
            4'h1: p = 7'h79;
            4'h2: p = 7'h24;
            4'h3: p = 7'h30;
            4'h4: p = 7'h19;
            4'h5: p = 7'h12;
            4'h6: p = 7'h02;
            4'h7: p = 7'h78;
            4'h8: p = 7'h00;
            4'h9: p = 7'h10;
            4'hA: p = 7'h08;
            4'hB: p = 7'h03;
            4'hC: p = 7'h46;
            4'hD: p = 7'h21;
            4'hE: p = 7'h06;
            default: p = 7'h0E;
        endcase
        return p;
    endfunction

    assign tick       = (div_cnt_q == CntW'(CLK_DIV - 1));
    assign frame_bnd  = tick && (digit_idx_q == 3'd7);
    assign load_ready = ~pending_full_q;
    assign xfer       = load_valid && load_ready;
    assign nibble     = shadow_q[{digit_idx_q, 2'b00} +: 4];

    always_comb begin
        div_cnt_d      = tick ? '0 : div_cnt_q + CntW'(1);
        digit_idx_d    = tick ? digit_idx_q + 3'd1 : digit_idx_q;
        shadow_d       = shadow_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        frame_done_d   = frame_bnd;

        if (frame_bnd && pending_full_q) begin
            shadow_d       = pending_q;
            pending_full_d = 1'b0;
        end
        // A transfer implies pending was empty, so it never collides with a commit.
        if (xfer) begin
            pending_d      = load_data;
            pending_full_d = 1'b1;
        end

        ans_d = ~(8'b1 << digit_idx_q);
        seg_d = hex7(nibble);
`ifdef LEADING_ZERO_BLANK_EN
        if ((digit_idx_q != 3'd0) && ((shadow_q >> {digit_idx_q, 2'b00}) == 32'd0)) begin
            ans_d = 8'hFF;
            seg_d = 7'h7F;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q      <= '0;
            digit_idx_q    <= 3'd0;
            shadow_q       <= 32'd0;
            pending_q      <= 32'd0;
            pending_full_q <= 1'b0;
            frame_done_q   <= 1'b0;
            seg_q          <= 7'h7F;
            ans_q          <= 8'hFF;
        end else begin
            div_cnt_q      <= div_cnt_d;
            digit_idx_q    <= digit_idx_d;
            shadow_q       <= shadow_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            frame_done_q   <= frame_done_d;
            seg_q          <= seg_d;
            ans_q          <= ans_d;
        end
    end

    assign frame_done = frame_done_q;
    assign seg        = seg_q;
    assign ans        = ans_q;

endmodule
